io_request_arbiter: RTL and testbench
=====================================

# io_request_arbiter

Shares the single system I/O bus port among all cores. It accepts I/O load/store requests from up to NUM_REQUESTERS cores and grants them round-robin. It issues one transaction at a time to the bus and waits for completion or timeout. It then returns a tagged response that is broadcast to all cores. It sits at the top level between the per-core I/O request outputs and the external I/O bus.

## Interface
Parameters:
- NUM_REQUESTERS, default 4: number of requesting cores, range 1..16.
- THREAD_IDX_WIDTH, default 2: width of the requesting-thread tag.
- TIMEOUT_CYCLES, default 1024: cycles spent in WAIT before an error response is forced; must be ≥ 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  [NUM_REQUESTERS]  request pending; held until accepted.
- req_store  in  [NUM_REQUESTERS]  1 = write, 0 = read.
- req_address  in  [NUM_REQUESTERS][32]  byte address.
- req_write_data  in  [NUM_REQUESTERS][32]  store data.
- req_thread  in  [NUM_REQUESTERS][THREAD_IDX_WIDTH]  issuing thread.
- req_ready  out  [NUM_REQUESTERS]  one-hot, one-cycle pulse marking acceptance of that requester's request.
- bus_write_en  out  1  one-cycle write strobe.
- bus_read_en  out  1  one-cycle read strobe.
- bus_address  out  32  held from issue through completion.
- bus_write_data  out  32  held from issue through completion.
- bus_read_data  in  32  valid when bus_complete is high.
- bus_complete  in  1  target finished the transaction.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_core  out  RW  requester index; RW = max(1, $clog2(NUM_REQUESTERS)).
- rsp_thread  out  THREAD_IDX_WIDTH  thread tag.
- rsp_read_data  out  32  read data; 0 for stores and timeouts.
- rsp_error  out  1  transaction timed out.

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESPOND.
- **IDLE**
  - If any req_valid is set, select the first set requester scanning from last_grant+1 and wrapping modulo NUM_REQUESTERS.
  - Pulse req_ready[sel] in the same cycle; req_ready is combinational from the state and req_valid.
  - Latch store, address, data, thread and sel; update last_grant to sel; go to ISSUE.
  - A requester that drops valid before being granted is simply skipped.
- **ISSUE**
  - Assert bus_write_en if the latched store bit is set, otherwise bus_read_en, for exactly one cycle.
  - Clear the timeout counter; go to WAIT.
  - bus_complete is ignored in ISSUE.
- **WAIT**
  - On bus_complete, capture bus_read_data (forced to 0 for stores), set error to 0 and go to RESPOND.
  - Otherwise increment the counter; when it reaches TIMEOUT_CYCLES-1, set error to 1, data to 0 and go to RESPOND.
  - bus_complete in the same cycle as the timeout wins: no error.
- **RESPOND**
  - Drive rsp_valid=1 for one cycle with the latched core, thread, data and error.
  - Return to IDLE. No grant is made in RESPOND.
- Only one transaction is ever outstanding.
- Reset values:
  - FSM = IDLE.
  - last_grant = NUM_REQUESTERS-1, so requester 0 wins first.
  - All outputs are 0 and the counter is 0.
- Reset asserted mid-transaction drops the transaction with no response. The bus strobes drop immediately.

## Timing
- Grant in cycle T, bus strobe in T+1.
- bus_complete is sampled from T+2 on. If it is seen in cycle C, rsp_valid is asserted in C+1.
- Minimum request-to-response latency is 3 cycles.
- Minimum spacing between grants is 4 cycles (IDLE → ISSUE → WAIT → RESPOND → IDLE).
- Timeout response is asserted at T+2+TIMEOUT_CYCLES.
- The bus_address and bus_write_data outputs are registered and stable from T+1 until the cycle the FSM leaves WAIT.
- All rsp_* fields are registered. rsp_core, rsp_thread and rsp_read_data may hold stale values when rsp_valid=0.

## Structure
- Shared package:
  - Add the constants IO_ADDR_WIDTH=32 and IO_DATA_WIDTH=32.
  - The state enum io_arb_state_t stays local to the module.
- Sub-module io_rr_select: purely combinational priority rotate.
  - Inputs: request vector and last_grant.
  - Outputs: one-hot grant, encoded index and any_valid.
  - It is reused for future shared-port arbiters.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Single read, core 2, address 0x100, thread 1, bus_complete 2 cycles after the strobe with data 0xDEADBEEF:
  - req_ready[2] at T, bus_read_en at T+1.
  - Response: rsp_valid, rsp_core=2, rsp_thread=1, data 0xDEADBEEF, error 0.
- All 4 cores hold valid simultaneously, with bus_complete one cycle after each strobe:
  - Grants occur in order 0,1,2,3, spaced 4 cycles apart.
  - Core 0 re-requests and wins only after core 3.
- Store from core 1 (0x200 ← 0x12345678), bus_read_data driven to 0xFFFFFFFF:
  - bus_write_en is high for one cycle, and address and data stay stable until complete.
  - rsp_read_data is 0.
- Target never completes (TIMEOUT_CYCLES=16):
  - rsp_valid with rsp_error=1 and data 0 arrives 16 cycles after WAIT entry.
  - The next pending request is then granted.
- bus_complete coincides with the timeout cycle -> rsp_error=0 and the data is captured.
- Reset asserted in WAIT:
  - All outputs go to 0 and no rsp_valid is produced.
  - After release, requester 0 wins over requester 3 when both are valid.

Source files
------------

// File: rtl/io_request_arbiter_pkg.sv
// Shared definitions for the I/O request arbiter and other shared-port arbiters.
// Holds bus widths and the helper that sizes requester index fields.
package io_request_arbiter_pkg;

    localparam int IO_ADDR_WIDTH = 32;
    localparam int IO_DATA_WIDTH = 32;

    // A single requester still needs a 1-bit index field.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_request_arbiter_if.sv
// Bundles the core request, I/O bus and response signals of the arbiter.
// master = arbiter side, slave = cores/bus-target side.
interface io_request_arbiter_if
    import io_request_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS   = 4,
    parameter int THREAD_IDX_WIDTH = 2
);
    localparam int RW = sel_width(NUM_REQUESTERS);

    logic [NUM_REQUESTERS-1:0]                        req_valid;
    logic [NUM_REQUESTERS-1:0]                        req_store;
    logic [NUM_REQUESTERS-1:0][IO_ADDR_WIDTH-1:0]     req_address;
    logic [NUM_REQUESTERS-1:0][IO_DATA_WIDTH-1:0]     req_write_data;
    logic [NUM_REQUESTERS-1:0][THREAD_IDX_WIDTH-1:0]  req_thread;
    logic [NUM_REQUESTERS-1:0]                        req_ready;

    logic                      bus_write_en;
    logic                      bus_read_en;
    logic [IO_ADDR_WIDTH-1:0]  bus_address;
    logic [IO_DATA_WIDTH-1:0]  bus_write_data;
    logic [IO_DATA_WIDTH-1:0]  bus_read_data;
    logic                      bus_complete;

    logic                         rsp_valid;
    logic [RW-1:0]                rsp_core;
    logic [THREAD_IDX_WIDTH-1:0]  rsp_thread;
    logic [IO_DATA_WIDTH-1:0]     rsp_read_data;
    logic                         rsp_error;

    modport master (
        input  req_valid, req_store, req_address, req_write_data, req_thread,
        output req_ready,
        output bus_write_en, bus_read_en, bus_address, bus_write_data,
        input  bus_read_data, bus_complete,
        output rsp_valid, rsp_core, rsp_thread, rsp_read_data, rsp_error
    );

    modport slave (
        output req_valid, req_store, req_address, req_write_data, req_thread,
        input  req_ready,
        input  bus_write_en, bus_read_en, bus_address, bus_write_data,
        output bus_read_data, bus_complete,
        input  rsp_valid, rsp_core, rsp_thread, rsp_read_data, rsp_error
    );

endinterface

// File: rtl/io_request_arbiter_rr_select.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
// Kept generic so other shared-port arbiters can reuse it.
module io_rr_select
    import io_request_arbiter_pkg::*;
#(
    parameter  int NUM_REQUESTERS = 4,
    localparam int RW             = sel_width(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] req,
    input  logic [RW-1:0]             last_grant,
    output logic [NUM_REQUESTERS-1:0] grant,
    output logic [RW-1:0]             grant_idx,
    output logic                      any_valid
);

    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        j         = 0;
        for (int i = 1; i <= NUM_REQUESTERS; i++) begin
            j = int'(last_grant) + i;
            if (j >= NUM_REQUESTERS) j = j - NUM_REQUESTERS;
            if (!any_valid && req[j]) begin
                any_valid = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = RW'(j);
            end
        end
    end

endmodule

// File: rtl/io_request_arbiter.sv
// Shares the single I/O bus among cores: round-robin grant, one transaction in
// flight, timeout protection and a tagged response broadcast to all cores.
module io_request_arbiter
    import io_request_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS   = 4,
    parameter int THREAD_IDX_WIDTH = 2,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    io_request_arbiter_if.master io
);

    localparam int RW = sel_width(NUM_REQUESTERS);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} io_arb_state_t;

    io_arb_state_t state, next_state;

    logic [RW-1:0]               last_grant;
    logic [RW-1:0]               grant_idx;
    logic [NUM_REQUESTERS-1:0]   grant_oh;
    logic                        any_valid;
    logic [RW-1:0]               core_q;
    logic [THREAD_IDX_WIDTH-1:0] thread_q;
    logic                        store_q;
    logic [CW-1:0]               count;
    logic                        take_grant;
    logic                        finish;
    logic                        timed_out;

    io_rr_select #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_select (
        .req        (io.req_valid),
        .last_grant (last_grant),
        .grant      (grant_oh),
        .grant_idx  (grant_idx),
        .any_valid  (any_valid)
    );

    always_comb begin
        next_state = state;
        take_grant = 1'b0;
        finish     = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    take_grant = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                // A completion arriving on the last wait cycle beats the timeout.
                if (io.bus_complete) begin
                    finish     = 1'b1;
                    next_state = RESPOND;
                end else if (count == LAST_WAIT) begin
                    finish     = 1'b1;
                    timed_out  = 1'b1;
                    next_state = RESPOND;
                end
            end
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign io.req_ready  = (take_grant && !reset) ? grant_oh : '0;
    assign io.rsp_core   = core_q;
    assign io.rsp_thread = thread_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant        <= RW'(NUM_REQUESTERS - 1);
            core_q            <= '0;
            thread_q          <= '0;
            store_q           <= 1'b0;
            count             <= '0;
            io.bus_write_en   <= 1'b0;
            io.bus_read_en    <= 1'b0;
            io.bus_address    <= '0;
            io.bus_write_data <= '0;
            io.rsp_valid      <= 1'b0;
            io.rsp_read_data  <= '0;
            io.rsp_error      <= 1'b0;
        end else begin
            io.bus_write_en <= take_grant &  io.req_store[grant_idx];
            io.bus_read_en  <= take_grant & ~io.req_store[grant_idx];
            io.rsp_valid    <= finish;
            if (take_grant) begin
                last_grant        <= grant_idx;
                core_q            <= grant_idx;
                thread_q          <= io.req_thread[grant_idx];
                store_q           <= io.req_store[grant_idx];
                io.bus_address    <= io.req_address[grant_idx];
                io.bus_write_data <= io.req_write_data[grant_idx];
            end
            if (state == ISSUE)
                count <= '0;
            else if (state == WAIT && !finish)
                count <= count + CW'(1);
            // Stores and timeouts return zero data so cores never see bus garbage.
            if (finish) begin
                io.rsp_error     <= timed_out;
                io.rsp_read_data <= (timed_out || store_q) ? '0 : io.bus_read_data;
            end
        end
    end

endmodule

// File: tb/tb_io_request_arbiter.sv
// Self-checking bench for io_request_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level round-robin model.
module tb_io_request_arbiter;

    localparam int N  = 4;
    localparam int TW = 2;
    localparam int TO = 16;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    io_request_arbiter_if #(.NUM_REQUESTERS(N), .THREAD_IDX_WIDTH(TW)) io();

    io_request_arbiter #(
        .NUM_REQUESTERS(N), .THREAD_IDX_WIDTH(TW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    int errors = 0;
    int checks = 0;
    int cyc_count = 0;
    int model_last;

    always @(posedge clk) cyc_count <= cyc_count + 1;

    logic [N-1:0]  obs_ready;
    int            obs_grant_cycle;
    logic          obs_rd, obs_wr, obs_err, obs_after;
    logic [31:0]   obs_addr, obs_wdata, obs_data;
    bit            obs_stable, obs_stray_strobe, obs_stray_ready;
    int            obs_lat;
    logic [RW-1:0] obs_core;
    logic [TW-1:0] obs_thread;

    logic [31:0]   m_addr[N];
    logic [31:0]   m_wdata[N];
    logic          m_store[N];
    logic [TW-1:0] m_thread[N];

    // Reference: first pending requester after the previous winner, wrapping.
    function automatic int model_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic bit model_done_in_time(input int d);
        return (d >= 1 && d <= TO);
    endfunction

    task automatic new_request(input int i);
        m_addr[i]   = $urandom();
        m_wdata[i]  = $urandom();
        m_store[i]  = 1'($urandom_range(0, 1));
        m_thread[i] = TW'($urandom_range(0, 3));
        io.req_address[i]    = m_addr[i];
        io.req_write_data[i] = m_wdata[i];
        io.req_store[i]      = m_store[i];
        io.req_thread[i]     = m_thread[i];
        io.req_valid[i]      = 1'b1;
    endtask

    task automatic set_request(input int i, input logic st, input logic [31:0] a,
                               input logic [31:0] wd, input logic [TW-1:0] th);
        m_addr[i] = a; m_wdata[i] = wd; m_store[i] = st; m_thread[i] = th;
        io.req_address[i] = a; io.req_write_data[i] = wd;
        io.req_store[i] = st;  io.req_thread[i] = th;
        io.req_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        io.req_valid = '0; io.bus_complete = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_last = N - 1;
    endtask

    // Runs one transaction from its IDLE cycle (inputs already driven) through
    // the cycle after the response, recording what the DUT did. d = cycles from
    // strobe to bus_complete, 0 = target never completes.
    task automatic run_txn(input int d, input logic [31:0] rdata);
        @(negedge clk);
        obs_ready = io.req_ready;
        obs_grant_cycle = cyc_count;
        @(posedge clk); #1;
        io.req_valid = io.req_valid & ~obs_ready;
        @(negedge clk);
        obs_rd = io.bus_read_en; obs_wr = io.bus_write_en;
        obs_addr = io.bus_address; obs_wdata = io.bus_write_data;
        obs_stray_ready = (io.req_ready != '0);
        obs_stable = 1'b1; obs_stray_strobe = 1'b0; obs_lat = -1;
        for (int k = 2; k < TO + 12; k++) begin
            @(posedge clk); #1;
            io.bus_complete  = (d != 0 && k == 1 + d);
            io.bus_read_data = io.bus_complete ? rdata : $urandom();
            @(negedge clk);
            if (io.req_ready != '0) obs_stray_ready = 1'b1;
            if (io.bus_read_en || io.bus_write_en) obs_stray_strobe = 1'b1;
            if (io.rsp_valid) begin
                obs_lat = k; obs_core = io.rsp_core; obs_thread = io.rsp_thread;
                obs_data = io.rsp_read_data; obs_err = io.rsp_error;
                break;
            end
            if (io.bus_address !== obs_addr || io.bus_write_data !== obs_wdata)
                obs_stable = 1'b0;
        end
        @(posedge clk); #1;
        io.bus_complete = 1'b0;
        obs_after = io.rsp_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io.req_valid = '1;
        @(negedge clk); @(negedge clk);
        checks++; if (io.req_ready !== '0) begin errors++; $display("[TB] FAIL reset_req_ready got=%b exp=0", io.req_ready); end
        checks++; if (io.bus_write_en !== 1'b0 || io.bus_read_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes got=%b%b exp=00", io.bus_write_en, io.bus_read_en); end
        checks++; if (io.bus_address !== '0 || io.bus_write_data !== '0) begin errors++; $display("[TB] FAIL reset_bus got=%h/%h exp=0/0", io.bus_address, io.bus_write_data); end
        checks++; if (io.rsp_valid !== 1'b0 || io.rsp_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_flags got=%b%b exp=00", io.rsp_valid, io.rsp_error); end
        checks++; if (io.rsp_core !== '0 || io.rsp_thread !== '0 || io.rsp_read_data !== '0) begin errors++; $display("[TB] FAIL reset_rsp_fields got=%0d/%0d/%h exp=0", io.rsp_core, io.rsp_thread, io.rsp_read_data); end
        @(posedge clk); #1;
        reset = 1'b0;
        io.req_valid = '0;
        model_last = N - 1;
    endtask

    task automatic test_single_read();
        set_request(2, 1'b0, 32'h100, 32'h0, 2'd1);
        run_txn(2, 32'hDEADBEEF);
        checks++; if (obs_ready !== 4'b0100) begin errors++; $display("[TB] FAIL single_ready got=%b exp=0100", obs_ready); end
        checks++; if (obs_rd !== 1'b1 || obs_wr !== 1'b0) begin errors++; $display("[TB] FAIL single_strobe got rd=%b wr=%b exp rd=1 wr=0", obs_rd, obs_wr); end
        checks++; if (obs_addr !== 32'h100) begin errors++; $display("[TB] FAIL single_addr got=%h exp=100", obs_addr); end
        checks++; if (obs_lat !== 4) begin errors++; $display("[TB] FAIL single_latency got=%0d exp=4", obs_lat); end
        checks++; if (obs_core !== 2'd2 || obs_thread !== 2'd1) begin errors++; $display("[TB] FAIL single_tag got=%0d/%0d exp=2/1", obs_core, obs_thread); end
        checks++; if (obs_data !== 32'hDEADBEEF || obs_err !== 1'b0) begin errors++; $display("[TB] FAIL single_data got=%h err=%b exp=deadbeef err=0", obs_data, obs_err); end
        checks++; if (obs_after !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse got=%b exp=0", obs_after); end
        model_last = 2;
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        int prev_cycle = 0;
        do_reset();
        for (int i = 0; i < N; i++) set_request(i, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, TW'(i));
        for (int k = 0; k < 5; k++) begin
            if (k == 1) io.req_valid[0] = 1'b1;
            run_txn(1, 32'hA000_0000 + 32'(k));
            checks++; if (obs_ready !== N'(1 << order[k])) begin errors++; $display("[TB] FAIL rr_order k=%0d got=%b exp=%0d", k, obs_ready, order[k]); end
            checks++; if (obs_lat !== 3 || obs_data !== 32'hA000_0000 + 32'(k)) begin errors++; $display("[TB] FAIL rr_rsp k=%0d got lat=%0d data=%h exp lat=3", k, obs_lat, obs_data); end
            if (k > 0) begin
                checks++; if (obs_grant_cycle - prev_cycle !== 4) begin errors++; $display("[TB] FAIL rr_spacing k=%0d got=%0d exp=4", k, obs_grant_cycle - prev_cycle); end
            end
            prev_cycle = obs_grant_cycle;
        end
        model_last = 0;
    endtask

    task automatic test_store();
        set_request(1, 1'b1, 32'h200, 32'h12345678, 2'd3);
        run_txn(3, 32'hFFFFFFFF);
        checks++; if (obs_ready !== 4'b0010) begin errors++; $display("[TB] FAIL store_ready got=%b exp=0010", obs_ready); end
        checks++; if (obs_wr !== 1'b1 || obs_rd !== 1'b0 || obs_stray_strobe) begin errors++; $display("[TB] FAIL store_strobe got wr=%b rd=%b extra=%b exp wr=1 rd=0 extra=0", obs_wr, obs_rd, obs_stray_strobe); end
        checks++; if (obs_addr !== 32'h200 || obs_wdata !== 32'h12345678 || !obs_stable) begin errors++; $display("[TB] FAIL store_bus got=%h/%h stable=%b exp=200/12345678 stable=1", obs_addr, obs_wdata, obs_stable); end
        checks++; if (obs_data !== '0 || obs_err !== 1'b0 || obs_core !== 2'd1 || obs_lat !== 5) begin errors++; $display("[TB] FAIL store_rsp got data=%h err=%b core=%0d lat=%0d exp 0/0/1/5", obs_data, obs_err, obs_core, obs_lat); end
        model_last = 1;
    endtask

    task automatic test_timeout();
        int first_cycle;
        set_request(0, 1'b0, 32'h40, 32'h0, 2'd2);
        set_request(3, 1'b0, 32'h80, 32'h0, 2'd0);
        run_txn(0, 32'h0);
        first_cycle = obs_grant_cycle;
        checks++; if (obs_ready !== N'(1 << model_pick(4'b1001, model_last))) begin errors++; $display("[TB] FAIL timeout_ready got=%b exp=1000", obs_ready); end
        checks++; if (obs_err !== 1'b1 || obs_data !== '0) begin errors++; $display("[TB] FAIL timeout_rsp got err=%b data=%h exp err=1 data=0", obs_err, obs_data); end
        checks++; if (obs_lat !== TO + 2 || obs_core !== 2'd3) begin errors++; $display("[TB] FAIL timeout_latency got=%0d core=%0d exp=%0d core=3", obs_lat, obs_core, TO + 2); end
        checks++; if (obs_stray_ready) begin errors++; $display("[TB] FAIL timeout_busy_grant got=1 exp=0"); end
        run_txn(1, 32'h5555AAAA);
        checks++; if (obs_ready !== 4'b0001 || obs_grant_cycle - first_cycle !== TO + 3) begin errors++; $display("[TB] FAIL timeout_next got=%b gap=%0d exp=0001 gap=%0d", obs_ready, obs_grant_cycle - first_cycle, TO + 3); end
        checks++; if (obs_data !== 32'h5555AAAA || obs_err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_next_rsp got=%h err=%b exp=5555aaaa err=0", obs_data, obs_err); end
        model_last = 0;
    endtask

    task automatic test_coincide();
        set_request(2, 1'b0, 32'hC0, 32'h0, 2'd1);
        run_txn(TO, 32'hCAFEF00D);
        checks++; if (obs_err !== 1'b0 || obs_data !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL coincide_rsp got err=%b data=%h exp err=0 data=cafef00d", obs_err, obs_data); end
        checks++; if (obs_lat !== TO + 2) begin errors++; $display("[TB] FAIL coincide_latency got=%0d exp=%0d", obs_lat, TO + 2); end
        model_last = 2;
    endtask

    task automatic test_reset_mid_wait();
        bit saw_rsp = 1'b0;
        set_request(2, 1'b0, 32'h300, 32'h0, 2'd3);
        @(posedge clk); #1;
        io.req_valid[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        set_request(0, 1'b0, 32'h10, 32'h0, 2'd1);
        set_request(3, 1'b0, 32'h30, 32'h0, 2'd2);
        io.bus_complete = 1'b1; io.bus_read_data = 32'h1234;
        #1;
        checks++; if (io.bus_address !== '0 || io.bus_read_en !== 1'b0 || io.bus_write_en !== 1'b0) begin errors++; $display("[TB] FAIL midreset_bus got=%h rd=%b wr=%b exp=0", io.bus_address, io.bus_read_en, io.bus_write_en); end
        checks++; if (io.req_ready !== '0 || io.rsp_valid !== 1'b0 || io.rsp_core !== '0) begin errors++; $display("[TB] FAIL midreset_outputs got ready=%b rsp=%b core=%0d exp=0", io.req_ready, io.rsp_valid, io.rsp_core); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (io.rsp_valid) saw_rsp = 1'b1;
        end
        checks++; if (saw_rsp) begin errors++; $display("[TB] FAIL midreset_no_rsp got=1 exp=0"); end
        @(posedge clk); #1;
        reset = 1'b0; io.bus_complete = 1'b0;
        model_last = N - 1;
        run_txn(1, 32'h0BAD_F00D);
        checks++; if (obs_ready !== N'(1 << model_pick(4'b1001, model_last))) begin errors++; $display("[TB] FAIL midreset_first got=%b exp=0001", obs_ready); end
        checks++; if (obs_core !== 2'd0 || obs_data !== 32'h0BAD_F00D || obs_err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_rsp got core=%0d data=%h err=%b exp 0/0badf00d/0", obs_core, obs_data, obs_err); end
        model_last = 0;
        run_txn(1, 32'h0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            int exp_idx, d, r;
            logic [31:0] rdata, exp_data;
            logic exp_err;
            int exp_lat;
            for (int i = 0; i < N; i++) begin
                if (!io.req_valid[i] && $urandom_range(0, 1) == 1) new_request(i);
                else if (io.req_valid[i] && $urandom_range(0, 7) == 0) io.req_valid[i] = 1'b0;
            end
            if (io.req_valid == '0) new_request(int'($urandom_range(0, N - 1)));
            exp_idx = model_pick(io.req_valid, model_last);
            r = int'($urandom_range(0, 9));
            d = (r == 9) ? TO : r;
            rdata = $urandom();
            exp_err  = !model_done_in_time(d);
            exp_lat  = exp_err ? TO + 2 : d + 2;
            exp_data = (exp_err || m_store[exp_idx]) ? 32'h0 : rdata;
            run_txn(d, rdata);
            checks++; if (obs_ready !== N'(1 << exp_idx)) begin errors++; $display("[TB] FAIL rand_grant t=%0d got=%b exp=%0d", t, obs_ready, exp_idx); end
            checks++; if (obs_wr !== m_store[exp_idx] || obs_rd !== !m_store[exp_idx] || obs_stray_strobe) begin errors++; $display("[TB] FAIL rand_strobe t=%0d got wr=%b rd=%b extra=%b exp store=%b", t, obs_wr, obs_rd, obs_stray_strobe, m_store[exp_idx]); end
            checks++; if (obs_addr !== m_addr[exp_idx] || obs_wdata !== m_wdata[exp_idx] || !obs_stable) begin errors++; $display("[TB] FAIL rand_bus t=%0d got=%h/%h stable=%b exp=%h/%h", t, obs_addr, obs_wdata, obs_stable, m_addr[exp_idx], m_wdata[exp_idx]); end
            checks++; if (obs_lat !== exp_lat || obs_stray_ready || obs_after !== 1'b0) begin errors++; $display("[TB] FAIL rand_timing t=%0d got lat=%0d busy_grant=%b after=%b exp lat=%0d", t, obs_lat, obs_stray_ready, obs_after, exp_lat); end
            checks++; if (obs_core !== RW'(exp_idx) || obs_thread !== m_thread[exp_idx]) begin errors++; $display("[TB] FAIL rand_tag t=%0d got=%0d/%0d exp=%0d/%0d", t, obs_core, obs_thread, exp_idx, m_thread[exp_idx]); end
            checks++; if (obs_data !== exp_data || obs_err !== exp_err) begin errors++; $display("[TB] FAIL rand_rsp t=%0d got=%h err=%b exp=%h err=%b", t, obs_data, obs_err, exp_data, exp_err); end
            model_last = exp_idx;
        end
    endtask

    initial begin
        io.req_valid = '0; io.req_store = '0; io.req_address = '0;
        io.req_write_data = '0; io.req_thread = '0;
        io.bus_read_data = '0; io.bus_complete = 1'b0;
        model_last = N - 1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_store();
        test_timeout();
        test_coincide();
        test_reset_mid_wait();
        do_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
